pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard controller for the pipelined ARM core: operand forwarding, load-use interlock, branch/PC-write flushing, a multi-cycle multiply interlock and a variable-latency data-memory wait with timeout. It sits beside the F/D/E/M/W datapath. It takes register indices, write enables and control strobes from each stage, and returns per-stage stall/flush strobes and forwarding selects. Forwarding and stall decisions are combinational. The multiply and memory-wait trackers are registered state machines.

## Interface
Parameters:
- NREG, 16, architectural register count; RW = $clog2(NREG)
- PC_IDX, NREG-1, register index that reads the PC; never forwarded
- MUL_CYCLES, 3, execute-stage occupancy of a multiply (1..15); 1 means no stall
- MEM_TIMEOUT, 64, wait cycles before a memory access is declared dead (2..255)

Ports (clock is `clk`, reset is `reset_n`):
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- ra1D, ra2D  in  RW  source indices in Decode
- ra1E, ra2E  in  RW  source indices in Execute
- wa3E, wa3M, wa3W  in  RW  destination indices per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  destination valid per stage
- MemtoRegE  in  1  Execute holds a load
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  instruction writes PC
- BranchTakenE  in  1  branch resolved taken in Execute
- MulStartE  in  1  multiply enters Execute this cycle
- MemReqM, MemReadyM  in  1  data-memory request / completion
- ForwardAE, ForwardBE  out  2  10 = M result, 01 = W result, 00 = register file
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE, FlushM, FlushW  out  1  bubble into stage register
- MulBusy  out  1  multiply tracker not idle
- MemTimeout  out  1  sticky timeout flag

## Operation
- Forwarding (ForwardAE; B identical on ra2E):
  - 10 if RegWriteM & wa3M==ra1E.
  - Else 01 if RegWriteW & wa3W==ra1E.
  - Else 00.
  - Forced 00 when ra1E==PC_IDX.
- Load-use: ldrStall = MemtoRegE & RegWriteE & (ra1D==wa3E | ra2D==wa3E), ignoring PC_IDX sources.
- PCWrPending = PCSrcD | PCSrcE | PCSrcM.
- Multiply FSM M_IDLE/M_BUSY:
  - In M_IDLE, MulStartE with MUL_CYCLES>1 loads mul_cnt = MUL_CYCLES-2 and enters M_BUSY.
  - In M_BUSY, mul_cnt decrements each cycle. At 0 it returns to M_IDLE.
  - mulStall = (M_IDLE & MulStartE & MUL_CYCLES>1) | M_BUSY.
  - MulStartE while in M_BUSY is ignored.
- Memory FSM W_IDLE/W_WAIT:
  - memStall = MemReqM & !MemReadyM & !timeout_hit.
  - W_IDLE → W_WAIT on memStall, with wait_cnt = 1.
  - W_WAIT increments wait_cnt each cycle. It returns to W_IDLE on MemReadyM or !MemReqM.
  - When wait_cnt reaches MEM_TIMEOUT: timeout_hit pulses for one cycle, memStall drops, MemTimeout sets, and the FSM returns to W_IDLE.
- Priority (highest first):
  - memStall: StallF/D/E/M=1, FlushW=1; all other flushes 0.
  - mulStall: StallF/D/E=1, FlushM=1.
  - ldrStall: StallF/D=1, FlushE=1.
- Then apply, OR'd into the above:
  - StallF |= PCWrPending.
  - FlushD |= PCWrPending | PCSrcW | BranchTakenE.
  - FlushE |= BranchTakenE.
  - BranchTakenE does not override a higher-priority stall: during memStall or mulStall it is held until release.
- The multiply counter keeps counting during memStall.

## Timing
- Forwarding and stall/flush outputs are combinational from inputs and current state; zero-cycle latency.
- Multiply with MUL_CYCLES=N stalls cycles t..t+N-2 (N-1 cycles). F/D/E advance at t+N-1.
- MemTimeout is registered: set one cycle after wait_cnt==MEM_TIMEOUT. It clears only on reset.
- Reset (reset_n=0 at a clk edge):
  - Both FSMs go idle; counters and MemTimeout go to 0.
  - While reset_n=0, all Stall*=0, all Flush*=1, Forward*=00, MulBusy=0, regardless of other inputs.
- Reset mid-multiply or mid-wait abandons the operation. There is no stall on the first cycle after reset.

## Configuration
- PIPE_HAZARD_FWD_EN defined: forwarding as described.
- Undefined:
  - Forward*E tied to 00.
  - A RAW stall replaces forwarding: rawStall = any D source (≠PC_IDX) matching a valid wa3E, wa3M or wa3W. It has ldrStall priority and effect.

## Structure
- hazard_pkg:
  - fwd_sel_t enum (FWD_RF=00, FWD_W=01, FWD_M=10).
  - mul_state_t and mem_state_t enums.
  - Width function for RW.
- One sub-module, hazard_wait_ctr: a loadable up/down counter with terminal-count flag, instantiated for mul_cnt (down) and wait_cnt (up).

## Test plan
- Forwarding:
  - wa3M=3, RegWriteM=1, wa3W=3, RegWriteW=1, ra1E=3 → ForwardAE=10.
  - With RegWriteM=0 → 01.
  - ra1E=15 → 00.
- Load-use: MemtoRegE=1, RegWriteE=1, wa3E=5, ra2D=5 → StallF=StallD=FlushE=1 for exactly one cycle.
- Multiply: MUL_CYCLES=3, MulStartE pulse at cycle 10 → StallE=1 and FlushM=1 in cycles 10–11, 0 at 12; MulBusy=1 in cycle 11 only.
- Memory wait: MemReqM held, MemReadyM rises at cycle 4 of the wait → StallM=1 for 3 cycles. With MemReadyM never rising and MEM_TIMEOUT=8 → stall releases after 8 cycles and MemTimeout=1 thereafter.
- Simultaneous events:
  - BranchTakenE with ldrStall → FlushD=FlushE=1, StallF=1.
  - memStall with BranchTakenE → only StallF/D/E/M and FlushW asserted.
- Reset: reset_n=0 during M_BUSY → next cycle MulBusy=0 and all Flush*=1. Releasing reset_n → no stall asserted.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the pipe_hazard_ctrl slice.
// Forward-select encoding, tracker FSM states and counter widths.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      M_IDLE = 1'b0,
      M_BUSY = 1'b1
   } mul_state_t;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_WAIT = 1'b1
   } mem_state_t;

   localparam int MUL_CW  = 4;
   localparam int WAIT_CW = 8;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hazard_wait_ctr.sv
// hazard_wait_ctr: loadable up/down counter with a terminal-count flag.
// Direction and terminal value are fixed per instance.
module hazard_wait_ctr #(
   parameter int           W    = 8,
   parameter bit           DOWN = 1'b0,
   parameter logic [W-1:0] TERM = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic         en_i,
   input  logic [W-1:0] load_val_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i)
         cnt_d = DOWN ? cnt_q - W'(1) : cnt_q + W'(1);
   end

   assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding, interlocks and flush control for the ARM pipe.
// PIPE_HAZARD_FWD_EN enables forwarding; otherwise RAW hazards stall Decode.
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter  int NREG        = 16,
   parameter  int PC_IDX      = NREG - 1,
   parameter  int MUL_CYCLES  = 3,
   parameter  int MEM_TIMEOUT = 64,
   localparam int RW          = idx_w(NREG)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [RW-1:0] ra1D,
   input  logic [RW-1:0] ra2D,
   input  logic [RW-1:0] ra1E,
   input  logic [RW-1:0] ra2E,
   input  logic [RW-1:0] wa3E,
   input  logic [RW-1:0] wa3M,
   input  logic [RW-1:0] wa3W,
   input  logic          RegWriteE,
   input  logic          RegWriteM,
   input  logic          RegWriteW,
   input  logic          MemtoRegE,
   input  logic          PCSrcD,
   input  logic          PCSrcE,
   input  logic          PCSrcM,
   input  logic          PCSrcW,
   input  logic          BranchTakenE,
   input  logic          MulStartE,
   input  logic          MemReqM,
   input  logic          MemReadyM,
   output logic [1:0]    ForwardAE,
   output logic [1:0]    ForwardBE,
   output logic          StallF,
   output logic          StallD,
   output logic          StallE,
   output logic          StallM,
   output logic          FlushD,
   output logic          FlushE,
   output logic          FlushM,
   output logic          FlushW,
   output logic          MulBusy,
   output logic          MemTimeout
);

   localparam logic [RW-1:0]     PC_R     = RW'(PC_IDX);
   localparam bit                MUL_MC   = (MUL_CYCLES > 1);
   localparam bit                MUL_LONG = (MUL_CYCLES > 2);
   localparam logic [MUL_CW-1:0] MUL_LOAD = MUL_CW'(MUL_CYCLES - 2);

   function automatic fwd_sel_t fwd_sel(
      input logic [RW-1:0] ra,
      input logic [RW-1:0] m,
      input logic [RW-1:0] w,
      input logic          vm,
      input logic          vw
   );
      fwd_sel_t s;
      s = FWD_RF;
      if (ra != PC_R) begin
         if (vm && m == ra)      s = FWD_M;
         else if (vw && w == ra) s = FWD_W;
      end
      return s;
   endfunction

   function automatic logic raw_hit(
      input logic [RW-1:0] ra,
      input logic [RW-1:0] e,
      input logic [RW-1:0] m,
      input logic [RW-1:0] w,
      input logic          ve,
      input logic          vm,
      input logic          vw
   );
      return (ra != PC_R) &
             ((ve & ra == e) | (vm & ra == m) | (vw & ra == w));
   endfunction

   mul_state_t mul_q, mul_d;
   mem_state_t mem_q, mem_d;
   logic       tmo_q, tmo_d;
   logic       mul_load, mul_en, mul_tc, mul_go;
   logic       wt_load, wt_en, wt_tc;
   logic       mul_stall, mem_stall, timeout_hit;
   logic       ldr_stall, raw_stall, d_stall, pc_wr_pend;
   fwd_sel_t   fwd_a, fwd_b;

   assign ldr_stall = MemtoRegE & RegWriteE &
                      ((ra1D == wa3E & ra1D != PC_R) |
                       (ra2D == wa3E & ra2D != PC_R));

`ifdef PIPE_HAZARD_FWD_EN
   assign raw_stall = 1'b0;
   assign fwd_a = fwd_sel(ra1E, wa3M, wa3W, RegWriteM, RegWriteW);
   assign fwd_b = fwd_sel(ra2E, wa3M, wa3W, RegWriteM, RegWriteW);
`else
   logic unused_e;
   assign unused_e  = ^{ra1E, ra2E};
   assign raw_stall = raw_hit(ra1D, wa3E, wa3M, wa3W,
                              RegWriteE, RegWriteM, RegWriteW) |
                      raw_hit(ra2D, wa3E, wa3M, wa3W,
                              RegWriteE, RegWriteM, RegWriteW);
   assign fwd_a = FWD_RF;
   assign fwd_b = FWD_RF;
`endif

   assign d_stall    = ldr_stall | raw_stall;
   assign pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mul_q <= M_IDLE;
         mem_q <= W_IDLE;
         tmo_q <= 1'b0;
      end else begin
         mul_q <= mul_d;
         mem_q <= mem_d;
         tmo_q <= tmo_d;
      end
   end

   // Counter holds MUL_CYCLES-2 busy cycles; the start cycle itself stalls too
   assign mul_go = MulStartE & MUL_MC;

   always_comb begin
      mul_d    = mul_q;
      mul_load = 1'b0;
      mul_en   = 1'b0;
      unique case (mul_q)
         M_IDLE: if (mul_go) begin
            mul_load = 1'b1;
            if (MUL_LONG) mul_d = M_BUSY;
         end
         M_BUSY: begin
            mul_en = 1'b1;
            if (mul_tc) mul_d = M_IDLE;
         end
         default: mul_d = M_IDLE;
      endcase
   end

   assign mul_stall = ((mul_q == M_IDLE) & mul_go) | (mul_q == M_BUSY);

   assign timeout_hit = (mem_q == W_WAIT) & wt_tc;
   assign mem_stall   = MemReqM & ~MemReadyM & ~timeout_hit;
   assign tmo_d       = tmo_q | timeout_hit;

   always_comb begin
      mem_d   = mem_q;
      wt_load = 1'b0;
      wt_en   = 1'b0;
      unique case (mem_q)
         W_IDLE: if (mem_stall) begin
            wt_load = 1'b1;
            mem_d   = W_WAIT;
         end
         W_WAIT: begin
            if (timeout_hit | MemReadyM | ~MemReqM) mem_d = W_IDLE;
            else                                    wt_en = 1'b1;
         end
         default: mem_d = W_IDLE;
      endcase
   end

   hazard_wait_ctr #(
      .W    (MUL_CW),
      .DOWN (1'b1),
      .TERM (MUL_CW'(1))
   ) u_mul_ctr (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .load_i     (mul_load),
      .en_i       (mul_en),
      .load_val_i (MUL_LOAD),
      .tc_o       (mul_tc)
   );

   hazard_wait_ctr #(
      .W    (WAIT_CW),
      .DOWN (1'b0),
      .TERM (WAIT_CW'(MEM_TIMEOUT))
   ) u_wait_ctr (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .load_i     (wt_load),
      .en_i       (wt_en),
      .load_val_i (WAIT_CW'(1)),
      .tc_o       (wt_tc)
   );

   assign MulBusy    = reset_n & (mul_q == M_BUSY);
   assign MemTimeout = tmo_q;

   // A taken branch waits out mem/mul stalls; it is re-presented on release
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      if (!reset_n) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushM = 1'b1;
         FlushW = 1'b1;
      end else begin
         ForwardAE = fwd_a;
         ForwardBE = fwd_b;
         if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (mul_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            FlushD = pc_wr_pend | PCSrcW;
         end else begin
            StallF = d_stall | pc_wr_pend;
            StallD = d_stall;
            FlushE = d_stall | BranchTakenE;
            FlushD = pc_wr_pend | PCSrcW | BranchTakenE;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table, corner sequences and random stimulus
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

   localparam int MULN = 3;
   localparam int TMO  = 8;
`ifdef PIPE_HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic [3:0] ra1D, ra2D, ra1E, ra2E, wa3E, wa3M, wa3W;
   logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
   logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
   logic       BranchTakenE, MulStartE, MemReqM, MemReadyM;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, StallE, StallM;
   logic       FlushD, FlushE, FlushM, FlushW;
   logic       MulBusy, MemTimeout;

   pipe_hazard_ctrl #(
      .NREG(16), .MUL_CYCLES(MULN), .MEM_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .ra1D(ra1D), .ra2D(ra2D), .ra1E(ra1E), .ra2E(ra2E),
      .wa3E(wa3E), .wa3M(wa3M), .wa3W(wa3W),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
      .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
      .MulStartE(MulStartE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
      .MulBusy(MulBusy), .MemTimeout(MemTimeout)
   );

   // ctl = {RWE,RWM,RWW,MtoR,PCD,PCE,PCM,PCW,BrT,MulS}
   typedef struct packed {
      logic [3:0] ra1D, ra2D, ra1E, ra2E, wa3E, wa3M, wa3W;
      logic [9:0] ctl;
      logic       req, rdy;
   } in_t;

   // e = {sF,sD,sE,sM, fD,fE,fM,fW, fwdA,fwdB, MulBusy, MemTimeout}
   typedef struct packed {
      in_t         x;
      logic [13:0] e;
   } vec_t;

   int checks = 0;
   int errors = 0;

   int mul_left = 0;
   int waited   = 0;
   bit tmo_m    = 1'b0;

   function automatic in_t mk(input logic [3:0] a, b, c, d, e, f, g,
                              input logic [9:0] ctl);
      return in_t'({a, b, c, d, e, f, g, ctl, 2'b00});
   endfunction

   function automatic in_t memx(input bit req, rdy, input logic [9:0] ctl);
      in_t t;
      t = mk(1, 2, 0, 0, 0, 0, 0, ctl);
      t.req = req;
      t.rdy = rdy;
      return t;
   endfunction

   task automatic drive(input in_t x);
      ra1D = x.ra1D; ra2D = x.ra2D; ra1E = x.ra1E; ra2E = x.ra2E;
      wa3E = x.wa3E; wa3M = x.wa3M; wa3W = x.wa3W;
      {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcE,
       PCSrcM, PCSrcW, BranchTakenE, MulStartE} = x.ctl;
      MemReqM = x.req;
      MemReadyM = x.rdy;
   endtask

   function automatic logic [1:0] fsel(input logic [3:0] ra, input in_t x);
      if (ra == 4'd15) return 2'b00;
      if (x.ctl[8] && x.wa3M == ra) return 2'b10;
      if (x.ctl[7] && x.wa3W == ra) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit rawdep(input logic [3:0] ra, input in_t x);
      if (ra == 4'd15) return 1'b0;
      return (x.ctl[9] && ra == x.wa3E) || (x.ctl[8] && ra == x.wa3M) ||
             (x.ctl[7] && ra == x.wa3W);
   endfunction

   function automatic logic [13:0] model(input in_t x, input bit rn);
      logic [7:0] s;
      logic [1:0] fa, fb;
      bit hit, memst, mulst, dst, pcw, bt;
      if (!rn) return {8'b0000_1111, 4'b0000, 1'b0, tmo_m};
      bt    = x.ctl[1];
      hit   = (waited == TMO);
      memst = x.req && !x.rdy && !hit;
      mulst = (mul_left > 0) || (x.ctl[0] && MULN > 1);
      dst   = x.ctl[6] && x.ctl[9] &&
              ((x.ra1D != 15 && x.ra1D == x.wa3E) ||
               (x.ra2D != 15 && x.ra2D == x.wa3E));
      if (!FWD) dst = dst || rawdep(x.ra1D, x) || rawdep(x.ra2D, x);
      pcw = x.ctl[5] || x.ctl[4] || x.ctl[3];
      if (memst) begin
         s = 8'b1111_0001;
      end else if (mulst) begin
         s = 8'b1110_0010;
         s[3] = pcw || x.ctl[2];
      end else begin
         s = dst ? 8'b1100_0100 : 8'b0;
         s[7] = s[7] || pcw;
         s[3] = pcw || x.ctl[2] || bt;
         s[2] = s[2] || bt;
      end
      fa = FWD ? fsel(x.ra1E, x) : 2'b00;
      fb = FWD ? fsel(x.ra2E, x) : 2'b00;
      return {s, fa, fb, mul_left > 0, tmo_m};
   endfunction

   task automatic step(input in_t x, input bit rn);
      bit hit, memst;
      if (!rn) begin
         mul_left = 0;
         waited = 0;
         tmo_m = 1'b0;
         return;
      end
      hit   = (waited == TMO);
      memst = x.req && !x.rdy && !hit;
      if (hit) tmo_m = 1'b1;
      if (mul_left > 0) mul_left--;
      else if (x.ctl[0] && MULN > 1) mul_left = MULN - 2;
      if (waited == 0) begin
         if (memst) waited = 1;
      end else if (hit || x.rdy || !x.req) begin
         waited = 0;
      end else begin
         waited++;
      end
   endtask

   task automatic cycle(input in_t x, input bit rn, input string nm,
                        input bit use_c, input logic [13:0] ce);
      logic [13:0] act, me;
      drive(x);
      reset_n = rn;
      @(negedge clk);
      act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM,
             FlushW, ForwardAE, ForwardBE, MulBusy, MemTimeout};
      me = model(x, rn);
      checks++;
      if (act !== me) begin
         errors++;
         $display("FAIL %s model: got %b want %b", nm, act, me);
      end
      if (use_c) begin
         checks++;
         if (act !== ce) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, ce);
         end
      end
      @(posedge clk);
      step(x, rn);
      #1;
   endtask

   vec_t tv[12];
   in_t  r;

   initial begin
      tv[0]  = '{mk(1, 2, 3, 4, 0, 3, 3, 10'b0110000000),
                 FWD ? 14'b0000_0000_1000_00 : 14'b0};
      tv[1]  = '{mk(1, 2, 3, 4, 0, 3, 3, 10'b0010000000),
                 FWD ? 14'b0000_0000_0100_00 : 14'b0};
      tv[2]  = '{mk(1, 2, 15, 3, 0, 3, 0, 10'b0100000000),
                 FWD ? 14'b0000_0000_0010_00 : 14'b0};
      tv[3]  = '{mk(1, 5, 0, 0, 5, 0, 0, 10'b1001000000),
                 14'b1100_0100_0000_00};
      tv[4]  = '{mk(15, 2, 0, 0, 15, 0, 0, 10'b1001000000), 14'b0};
      tv[5]  = '{mk(1, 2, 0, 0, 0, 0, 1, 10'b0010000000),
                 FWD ? 14'b0 : 14'b1100_0100_0000_00};
      tv[6]  = '{mk(1, 2, 0, 0, 0, 0, 0, 10'b0000100000),
                 14'b1000_1000_0000_00};
      tv[7]  = '{mk(1, 2, 0, 0, 0, 0, 0, 10'b0000000100),
                 14'b0000_1000_0000_00};
      tv[8]  = '{mk(1, 2, 0, 0, 0, 0, 0, 10'b0000000010),
                 14'b0000_1100_0000_00};
      tv[9]  = '{mk(5, 2, 0, 0, 5, 0, 0, 10'b1001000010),
                 14'b1100_1100_0000_00};
      tv[10] = '{mk(1, 2, 0, 0, 2, 0, 0, 10'b1000000000),
                 FWD ? 14'b0 : 14'b1100_0100_0000_00};
      tv[11] = '{mk(1, 2, 7, 0, 0, 7, 0, 10'b0100001000),
                 FWD ? 14'b1000_1000_1000_00 : 14'b1000_1000_0000_00};

      reset_n = 1'b0;
      drive(memx(1'b0, 1'b0, 10'b0));
      @(posedge clk);
      #1;
      cycle(memx(1, 0, 10'b0000100001), 1'b0, "reset_hold", 1'b1,
            14'b0000_1111_0000_00);
      cycle(memx(0, 0, 10'b0), 1'b0, "reset_idle", 1'b1,
            14'b0000_1111_0000_00);

      for (int i = 0; i < 12; i++)
         cycle(tv[i].x, 1'b1, $sformatf("tbl%0d", i), 1'b1, tv[i].e);

      cycle(memx(0, 0, 10'b1), 1'b1, "mul_start", 1'b1,
            14'b1110_0010_0000_00);
      cycle(memx(0, 0, 10'b1), 1'b1, "mul_busy", 1'b1,
            14'b1110_0010_0000_10);
      cycle(memx(0, 0, 10'b0), 1'b1, "mul_done", 1'b1, 14'b0);

      cycle(memx(1, 0, 10'b0), 1'b1, "mem_w1", 1'b1, 14'b1111_0001_0000_00);
      cycle(memx(1, 0, 10'b10), 1'b1, "mem_branch", 1'b1,
            14'b1111_0001_0000_00);
      cycle(memx(1, 0, 10'b0), 1'b1, "mem_w3", 1'b1, 14'b1111_0001_0000_00);
      cycle(memx(1, 1, 10'b0), 1'b1, "mem_ready", 1'b1, 14'b0);
      cycle(memx(0, 0, 10'b0), 1'b1, "mem_idle", 1'b1, 14'b0);

      for (int k = 1; k <= TMO; k++)
         cycle(memx(1, 0, 10'b0), 1'b1, $sformatf("tmo_stall%0d", k), 1'b1,
               14'b1111_0001_0000_00);
      cycle(memx(1, 0, 10'b0), 1'b1, "tmo_release", 1'b1, 14'b0);
      cycle(memx(1, 0, 10'b0), 1'b1, "tmo_flag", 1'b1,
            14'b1111_0001_0000_01);
      cycle(memx(0, 0, 10'b0), 1'b1, "tmo_sticky", 1'b1,
            14'b0000_0000_0000_01);

      cycle(memx(0, 0, 10'b1), 1'b1, "rst_mulstart", 1'b1,
            14'b1110_0010_0000_01);
      cycle(memx(1, 0, 10'b0000100001), 1'b0, "rst_in_busy", 1'b1,
            14'b0000_1111_0000_01);
      cycle(memx(0, 0, 10'b0), 1'b1, "rst_release", 1'b1, 14'b0);

      for (int n = 0; n < 3000; n++) begin
         r.ra1D = ($urandom_range(0, 7) > 5) ? 4'd15 : 4'($urandom_range(0, 5));
         r.ra2D = ($urandom_range(0, 7) > 5) ? 4'd15 : 4'($urandom_range(0, 5));
         r.ra1E = ($urandom_range(0, 7) > 5) ? 4'd15 : 4'($urandom_range(0, 5));
         r.ra2E = ($urandom_range(0, 7) > 5) ? 4'd15 : 4'($urandom_range(0, 5));
         r.wa3E = ($urandom_range(0, 7) > 5) ? 4'd15 : 4'($urandom_range(0, 5));
         r.wa3M = 4'($urandom_range(0, 5));
         r.wa3W = 4'($urandom_range(0, 5));
         r.ctl[9] = 1'($urandom_range(0, 1));
         r.ctl[8] = 1'($urandom_range(0, 1));
         r.ctl[7] = 1'($urandom_range(0, 1));
         r.ctl[6] = ($urandom_range(0, 3) == 0);
         r.ctl[5] = ($urandom_range(0, 9) == 0);
         r.ctl[4] = ($urandom_range(0, 9) == 0);
         r.ctl[3] = ($urandom_range(0, 9) == 0);
         r.ctl[2] = ($urandom_range(0, 9) == 0);
         r.ctl[1] = ($urandom_range(0, 9) == 0);
         r.ctl[0] = ($urandom_range(0, 7) == 0);
         r.req    = ($urandom_range(0, 9) < 7);
         r.rdy    = ($urandom_range(0, 9) == 0);
         cycle(r, ($urandom_range(0, 199) != 0), "rand", 1'b0, 14'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
